keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex matrix keypad and delivers debounced key codes: one key per press, plus a 16-bit shift register of the last four keys entered. It is the input-side counterpart of `hex_display`. `hex_display` multiplexes outputs across a one-hot strobe. This block strobes keypad rows one-hot and reads the columns back. Its `value` output connects directly to `hex_display` `data`, so typed digits appear on the 4-digit display.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clk cycles each row is driven (dwell), ≥ 4.
- `DEBOUNCE`, default 4: consecutive identical full scans needed to accept a press or a release, ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cols`  in  4  keypad columns, active-low (board pull-ups); asynchronous to clk.
- `rows`  out  4  row strobe, active-low one-hot.
- `key`  out  4  code of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  high while an accepted key remains pressed (until release is debounced).
- `value`  out  16  shift register of the last four accepted keys; newest key in [3:0].

## Operation
- **Synchronisation.** `cols` passes through a 2-flop synchroniser before any use.
- **Row scanning.**
  - A dwell counter counts 0..SCAN_DIV-1, then wraps.
  - A row index 0..3 advances each time the dwell counter wraps, and wraps 3→0.
  - `rows` = ~(1 << row).
- **Column sampling.** The synchronised columns are sampled only on the last dwell cycle of each row (counter = SCAN_DIV-1), which gives the row line time to settle. Each sample goes into a 16-bit scan image at bit row*4+col (active-high).
- **Scan completion.** A scan is complete on the sample of row 3. Each complete scan is classified as one of:
  - NONE: image = 0.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set.
- **Key map** (row, col → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- **Debounce FSM.** The FSM acts only on scan-complete cycles.
  - IDLE:
    - SINGLE(c) → CAND, with cand=c and cnt=1.
    - NONE or MULTI → stay in IDLE.
  - CAND:
    - SINGLE(cand) → cnt+1.
    - SINGLE(other) → restart with cand=new code, cnt=1.
    - NONE or MULTI → IDLE.
    - When cnt reaches DEBOUNCE → PRESSED. On the next cycle:
      - `key_valid` = 1 for that cycle only;
      - `key` = cand;
      - `value` = {value[11:0], cand};
      - `key_held` = 1.
  - PRESSED:
    - NONE → REL, with cnt=1.
    - SINGLE or MULTI → stay. A second key pressed or a key change is ignored, and there is no auto-repeat.
  - REL:
    - NONE → cnt+1; when cnt reaches DEBOUNCE → IDLE and `key_held` = 0.
    - Any key seen → PRESSED, with no new `key_valid`.
  - With DEBOUNCE=1, IDLE goes straight to PRESSED, and PRESSED goes straight to IDLE on the first NONE.
- **Reset.** Reset mid-scan or mid-debounce aborts immediately. The partial scan image is discarded.

## Timing
- Reset values:
  - `rows` = 4'b1110;
  - `key` = 0, `key_valid` = 0, `key_held` = 0, `value` = 16'h0000;
  - dwell counter, row index, scan image, cnt and cand = 0;
  - state = IDLE.
- Scan period: 4·SCAN_DIV cycles.
- Column sample latency: 2 cycles of synchroniser delay. A press is seen by a scan only if it was stable at `cols` at least 2 cycles before that row's sample cycle.
- Press latency: `key_valid` rises 1 cycle after the scan-complete cycle of the DEBOUNCE-th consecutive matching scan.
- `key`, `value` and `key_held` update in the same cycle as `key_valid`.
- Release latency: `key_held` falls 1 cycle after the DEBOUNCE-th consecutive NONE scan-complete.
- All outputs are registered. There is no combinational path from `cols` to any output.

## Structure
- Package `keypad_pkg` contains:
  - FSM state enum (IDLE, CAND, PRESSED, REL);
  - scan class enum (NONE, SINGLE, MULTI);
  - 16-entry key-map constant array, indexed row*4+col.
- Sub-module `key_debounce_fsm`:
  - inputs: scan-complete strobe, class, code;
  - outputs: `key`, `key_valid`, `key_held`, `value`.
- The top level holds the synchroniser, the dwell/row counters, the scan image and the classifier.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2. The bench models the keypad by driving `cols` low when the pressed key's row is the active row.
- **Reset/strobe:** Release reset → `rows` = 1110, and all outputs = 0. After 4 cycles `rows` = 1101. The sequence wraps to 1110 after 16 cycles.
- **Single press:** Hold key r1c2 → exactly one `key_valid` pulse with `key`=6, `value`=0x0006, and `key_held`=1. On release, `key_held` falls after 2 empty scans.
- **Entry sequence:** Press/release C, A, F, E → `value`=0xCAFE with 4 pulses total. A fifth press of 0 → `value`=0xAFE0.
- **Bounce:** Glitch key 5 present for 1 scan, absent for 1, present for 1 → no `key_valid`. Holding it for 2 consecutive scans → `key`=5.
- **Multi/ghost:** Press 1 and 2 together from IDLE → no `key_valid`. Press 8, wait until accepted, then add 9 → no second pulse, and `key` stays 8.
- **Async reset:** Assert `rst_n` low mid-CAND → outputs clear with no clk edge needed. After release, a full DEBOUNCE interval is again required before any key is accepted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED,
        ST_REL
    } dbnc_state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } scan_class_e;

    // Indexed row*4+col; row 3 carries '*' as E and '#' as F.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Debounce FSM: turns per-scan classifications into single key events,
// a held flag and a shift register of the last four keys.
module key_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_done,
    input  scan_class_e scan_class,
    input  logic [3:0]  scan_code,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    dbnc_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   value_q, value_d;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            value_q     <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        cnt_inc = cnt_q + 1'b1;
        if (scan_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_class == CLS_SINGLE) begin
                        cand_d  = scan_code;
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_DONE) ? ST_PRESSED : ST_CAND;
                    end
                end
                ST_CAND: begin
                    if (scan_class == CLS_SINGLE && scan_code == cand_q) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == CNT_DONE) ? ST_PRESSED : ST_CAND;
                    end else if (scan_class == CLS_SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_class == CLS_NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_DONE) ? ST_IDLE : ST_REL;
                    end
                end
                ST_REL: begin
                    if (scan_class == CLS_NONE) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == CNT_DONE) ? ST_IDLE : ST_REL;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A new key is reported only on entry to PRESSED from IDLE/CAND, never from REL.
    always_comb begin
        key_valid_d = (state_d == ST_PRESSED) &&
                      (state_q == ST_IDLE || state_q == ST_CAND);
        key_d       = key_valid_d ? cand_d : key_q;
        value_d     = key_valid_d ? {value_q[11:0], cand_d} : value_q;
        key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_REL);
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign value     = value_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column synchroniser, row strobe, scan image and
// classifier feeding the debounce FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    cols_meta_q, cols_meta_d;
    logic [3:0]    cols_sync_q, cols_sync_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    rows_q, rows_d;
    logic [15:0]   image_q, image_d;
    logic          sample;
    logic          scan_done;
    scan_class_e   scan_class;
    logic [3:0]    scan_code;
    logic [4:0]    hits;
    logic [3:0]    first_idx;
    logic          found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_meta_q <= '1;
            cols_sync_q <= '1;
            dwell_q     <= '0;
            row_q       <= '0;
            rows_q      <= 4'b1110;
            image_q     <= '0;
        end else begin
            cols_meta_q <= cols_meta_d;
            cols_sync_q <= cols_sync_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            image_q     <= image_d;
        end
    end

    always_comb begin
        cols_meta_d = cols;
        cols_sync_d = cols_meta_q;
        sample      = (dwell_q == DWELL_LAST);
        dwell_d     = sample ? '0 : dwell_q + 1'b1;
        row_d       = sample ? row_q + 1'b1 : row_q;
        rows_d      = ~(4'b0001 << row_d);
        scan_done   = sample && (row_q == 2'd3);
        image_d     = image_q;
        if (sample) begin
            image_d[{row_q, 2'b00} +: 4] = ~cols_sync_q;
        end
    end

    // Classify the image including the row-3 sample taken this very cycle.
    always_comb begin
        hits      = '0;
        first_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (image_d[i]) begin
                hits = hits + 5'd1;
                if (!found) begin
                    first_idx = 4'(i);
                    found     = 1'b1;
                end
            end
        end
        if (hits == 5'd0) begin
            scan_class = CLS_NONE;
        end else if (hits == 5'd1) begin
            scan_class = CLS_SINGLE;
        end else begin
            scan_class = CLS_MULTI;
        end
        scan_code = KEY_MAP[first_idx];
    end

    key_debounce_fsm #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_done (scan_done),
        .scan_class(scan_class),
        .scan_code (scan_code),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value)
    );

    assign rows = rows_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model and a key-event scoreboard.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] value;

    typedef struct packed {
        logic [3:0]  key;
        logic [15:0] value;
    } exp_evt_t;

    localparam logic [3:0] KEYS [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    exp_evt_t    exp_q [$];
    logic [15:0] press_mask;
    logic [15:0] exp_value;
    int          n_checks;
    int          n_fail;
    int          pulse_cnt;
    int          exp_pulses;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cols     (cols),
        .rows     (rows),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held),
        .value    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (rows[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (press_mask[r*4+c]) cols[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1) begin
            exp_evt_t e;
            pulse_cnt++;
            check("pulse_expected", 16'(exp_q.size() > 0), 16'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("evt_key", 16'(key), 16'(e.key));
                check("evt_value", value, e.value);
                check("evt_held", 16'(key_held), 16'd1);
            end
        end
    end

    task automatic expect_key(input int idx);
        logic [3:0] code;
        code = KEYS[idx];
        exp_value = {exp_value[11:0], code};
        exp_q.push_back('{key: code, value: exp_value});
        exp_pulses++;
    endtask

    task automatic press_release(input int idx);
        expect_key(idx);
        press_mask = 16'd1 << idx;
        cycles(16);
        check("no_early_valid", 16'(pulse_cnt), 16'(exp_pulses - 1));
        cycles(40);
        check("pulse_count", 16'(pulse_cnt), 16'(exp_pulses));
        check("held_pressed", 16'(key_held), 16'd1);
        press_mask = '0;
        cycles(16);
        check("held_one_empty", 16'(key_held), 16'd1);
        cycles(48);
        check("held_released", 16'(key_held), 16'd0);
    endtask

    task automatic align_scan();
        int n;
        n = 0;
        while (rows !== 4'b0111 && n < 100) begin cycles(1); n++; end
        while (rows !== 4'b1110 && n < 100) begin cycles(1); n++; end
        check("align_in_time", 16'(n < 100), 16'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pulse_cnt  = 0;
        exp_pulses = 0;
        exp_value  = '0;
        press_mask = '0;
        rst_n      = 1'b0;
        cycles(3);
        rst_n = 1'b1;

        // Reset state and row strobe sequence
        check("rst_rows", 16'(rows), 16'b1110);
        check("rst_key", 16'(key), 16'h0);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_held", 16'(key_held), 16'h0);
        check("rst_value", value, 16'h0000);
        cycles(4);
        check("rows_r1", 16'(rows), 16'b1101);
        cycles(4);
        check("rows_r2", 16'(rows), 16'b1011);
        cycles(4);
        check("rows_r3", 16'(rows), 16'b0111);
        cycles(4);
        check("rows_wrap", 16'(rows), 16'b1110);

        // Single press of r1c2 -> 6
        press_release(6);
        check("single_value", value, 16'h0006);

        // Entry sequence C A F E, then 0
        press_release(11);
        press_release(3);
        press_release(14);
        press_release(12);
        check("cafe_value", value, 16'hCAFE);
        check("cafe_pulses", 16'(pulse_cnt), 16'd5);
        press_release(13);
        check("afe0_value", value, 16'hAFE0);

        // Bounce: key 5 present/absent/present on whole scans
        align_scan();
        press_mask = 16'd1 << 5;
        cycles(16);
        press_mask = '0;
        cycles(16);
        press_mask = 16'd1 << 5;
        cycles(16);
        press_mask = '0;
        cycles(48);
        check("bounce_no_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        press_release(5);
        check("bounce_key", 16'(key), 16'h5);

        // Ghost: 1 and 2 together from IDLE
        press_mask = (16'd1 << 0) | (16'd1 << 1);
        cycles(64);
        check("multi_no_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        press_mask = '0;
        cycles(64);

        // Hold 8, then add 9
        expect_key(9);
        press_mask = 16'd1 << 9;
        cycles(56);
        check("eight_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        press_mask = press_mask | (16'd1 << 10);
        cycles(64);
        check("add9_no_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        check("add9_key", 16'(key), 16'h8);
        check("add9_held", 16'(key_held), 16'd1);
        press_mask = '0;
        cycles(64);
        check("add9_released", 16'(key_held), 16'd0);

        // Asynchronous reset in the middle of CAND
        align_scan();
        press_mask = 16'd1 << 8;
        cycles(20);
        check("cand_no_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        #1 rst_n = 1'b0;
        #1;
        check("arst_value", value, 16'h0000);
        check("arst_key", 16'(key), 16'h0);
        check("arst_rows", 16'(rows), 16'b1110);
        cycles(2);
        rst_n = 1'b1;
        exp_value = '0;
        cycles(24);
        check("arst_no_early", 16'(pulse_cnt), 16'(exp_pulses));
        expect_key(8);
        cycles(24);
        check("arst_pulse", 16'(pulse_cnt), 16'(exp_pulses));
        check("arst_new_value", value, 16'h0007);
        press_mask = '0;
        cycles(64);
        check("arst_released", 16'(key_held), 16'd0);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
